line_buffer_win: RTL and testbench

Parametrised sliding-window line buffer for the image-processing datapath. Stores one image line of pixels in a circular buffer and presents a WIN-pixel horizontal window (oldest pixel in the MSBs) to the downstream convolution stage. Adds the occupancy tracking, full/empty flow control, flush and optional error flags that the first-generation 3-tap, 8-bit, 512-deep buffer lacked.

---
 rtl/line_buffer_win.sv | 98 +++++++++
 tb/tb_line_buffer_win.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/line_buffer_win.sv
// Sliding-window line buffer: circular pixel store presenting a WIN-pixel window, oldest pixel in the MSBs.
// Optional sticky overflow/underflow flags are built when LINEBUF_ERR_FLAGS_EN is defined.
module line_buffer_win #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int WIN      = 3,
  parameter int ADDR_W   = $clog2(LINE_LEN),
  parameter int CNT_W    = ADDR_W + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_data_valid,
  output logic                  o_ready,
  input  logic                  i_rd_data,
  output logic [WIN*DATA_W-1:0] o_data,
  output logic                  o_data_valid,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_ovf,
  output logic                  o_unf
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_LEN);
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN);

  logic [DATA_W-1:0] line_mem [LINE_LEN];
  logic [ADDR_W-1:0] wr_pntr;
  logic [ADDR_W-1:0] rd_pntr;
  logic [CNT_W-1:0]  count;
  logic              wr_fire;
  logic              rd_fire;

  // Flow control comes only from the registered count, so no input reaches an output combinationally.
  assign o_ready      = (count != FULL_CNT);
  assign o_data_valid = (count >= WIN_CNT);
  assign o_count      = count;

  assign wr_fire = i_data_valid & o_ready;
  assign rd_fire = i_rd_data & o_data_valid;

  // NOTE: the pixel array has no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_fire && !i_flush) begin
      line_mem[wr_pntr] <= i_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_pntr <= '0;
      rd_pntr <= '0;
      count   <= '0;
    end else if (i_flush) begin
      wr_pntr <= '0;
      rd_pntr <= '0;
      count   <= '0;
    end else begin
      if (wr_fire) wr_pntr <= wr_pntr + ADDR_W'(1);
      if (rd_fire) rd_pntr <= rd_pntr + ADDR_W'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    o_data = '0;
    if (o_data_valid) begin
      for (int k = 0; k < WIN; k++) begin
        o_data[(WIN-k)*DATA_W-1 -: DATA_W] = line_mem[rd_pntr + ADDR_W'(k)];
      end
    end
  end

`ifdef LINEBUF_ERR_FLAGS_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_ovf <= 1'b0;
      o_unf <= 1'b0;
    end else if (i_flush) begin
      o_ovf <= 1'b0;
      o_unf <= 1'b0;
    end else begin
      if (i_data_valid && !o_ready)     o_ovf <= 1'b1;
      if (i_rd_data && !o_data_valid)   o_unf <= 1'b1;
    end
  end
`else
  assign o_ovf = 1'b0;
  assign o_unf = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_win.sv
// Directed bench for line_buffer_win with an 8-deep, 3-wide, 8-bit configuration.
module tb_line_buffer_win;

  localparam int DATA_W   = 8;
  localparam int LINE_LEN = 8;
  localparam int WIN      = 3;
  localparam int CNT_W    = $clog2(LINE_LEN) + 1;

`ifdef LINEBUF_ERR_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic                  i_flush;
  logic [DATA_W-1:0]     i_data;
  logic                  i_data_valid;
  logic                  o_ready;
  logic                  i_rd_data;
  logic [WIN*DATA_W-1:0] o_data;
  logic                  o_data_valid;
  logic [CNT_W-1:0]      o_count;
  logic                  o_ovf;
  logic                  o_unf;

  int checks = 0;
  int errors = 0;

  line_buffer_win #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .WIN(WIN)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_ready      (o_ready),
    .i_rd_data    (i_rd_data),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_count      (o_count),
    .o_ovf        (o_ovf),
    .o_unf        (o_unf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, sample 1 time unit later.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic rd, input logic fl);
    i_data_valid = v;
    i_data       = d;
    i_rd_data    = rd;
    i_flush      = fl;
    @(posedge i_clk);
    #1;
    i_data_valid = 1'b0;
    i_rd_data    = 1'b0;
    i_flush      = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_count"}, 32'(o_count), 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_valid"}, 32'(o_data_valid), 32'd0);
    check({tag, "_data"},  32'(o_data), 32'h0);
    check({tag, "_ovf"},   32'(o_ovf), 32'd0);
    check({tag, "_unf"},   32'(o_unf), 32'd0);
  endtask

  initial begin
    i_rst = 1'b0; i_flush = 1'b0; i_data = '0; i_data_valid = 1'b0; i_rd_data = 1'b0;
    #12;
    check_idle("reset");
    @(negedge i_clk);
    i_rst = 1'b1;

    // First window forms after the third write.
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    check("w1_count", 32'(o_count), 32'd1);
    check("w1_valid", 32'(o_data_valid), 32'd0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    check("w2_valid", 32'(o_data_valid), 32'd0);
    check("w2_data",  32'(o_data), 32'h0);
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    check("w3_valid", 32'(o_data_valid), 32'd1);
    check("w3_data",  32'(o_data), 32'h101112);
    check("w3_count", 32'(o_count), 32'd3);

    // Sustained write+read keeps occupancy constant.
    cycle(1'b1, 8'h13, 1'b1, 1'b0);
    check("s1_data",  32'(o_data), 32'h111213);
    check("s1_count", 32'(o_count), 32'd3);
    cycle(1'b1, 8'h14, 1'b1, 1'b0);
    check("s2_data",  32'(o_data), 32'h121314);
    check("s2_count", 32'(o_count), 32'd3);

    // Fill to full.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h15 + i), 1'b0, 1'b0);
    check("full_count", 32'(o_count), 32'd8);
    check("full_ready", 32'(o_ready), 32'd0);
    check("full_data",  32'(o_data), 32'h121314);

    // Write while full is refused.
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_count", 32'(o_count), 32'd8);
    check("ovf_data",  32'(o_data), 32'h121314);
    check("ovf_flag",  32'(o_ovf), 32'(FLAGS));

    // Write+read when full: read pops, write refused (no write-through).
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    check("wr_rd_full_count", 32'(o_count), 32'd7);
    check("wr_rd_full_data",  32'(o_data), 32'h131415);
    check("wr_rd_full_ready", 32'(o_ready), 32'd1);
    cycle(1'b1, 8'h1A, 1'b0, 1'b0);
    check("refill_count", 32'(o_count), 32'd8);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_count", 32'(o_count), 32'd3);
    check("drain_data",  32'(o_data), 32'h18191A);
    check("ovf_sticky",  32'(o_ovf), 32'(FLAGS));

    // Flush overrides concurrent write and read.
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    check_idle("flush");

    // Drive rdPntr to 6 so the window wraps across the array end.
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    check("wrap_fill_count", 32'(o_count), 32'd8);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_pre_count", 32'(o_count), 32'd2);
    check("wrap_pre_valid", 32'(o_data_valid), 32'd0);

    // Read with fewer than WIN pixels is ignored.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_count", 32'(o_count), 32'd2);
    check("unf_data",  32'(o_data), 32'h0);
    check("unf_flag",  32'(o_unf), 32'(FLAGS));

    cycle(1'b1, 8'hA0, 1'b0, 1'b0);
    check("wrap_data",  32'(o_data), 32'hA6A7A0);
    check("wrap_count", 32'(o_count), 32'd3);
    check("unf_sticky", 32'(o_unf), 32'(FLAGS));
    check("ovf_clear",  32'(o_ovf), 32'd0);

    // Asynchronous reset mid-stream with 5 pixels buffered.
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    check("pre_rst_count", 32'(o_count), 32'd5);
    #1;
    i_rst = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge i_clk);
    i_rst = 1'b1;
    cycle(1'b1, 8'hD0, 1'b0, 1'b0);
    cycle(1'b1, 8'hD1, 1'b0, 1'b0);
    cycle(1'b1, 8'hD2, 1'b0, 1'b0);
    check("post_rst_data",  32'(o_data), 32'hD0D1D2);
    check("post_rst_count", 32'(o_count), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
